// File: rtl/jump_count_aggregator.sv
// +----------------------------------------------------------------------------+
// | jump_count_aggregator: pipelined popcount of range_checker hit pulses with |
// | a saturating running total, presented as a valid/ready final result.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jump_count_aggregator #(
  parameter int NUM_CHECKERS = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [NUM_CHECKERS-1:0] jump,
  input  logic [NUM_CHECKERS-1:0] done,
  output logic [COUNT_WIDTH-1:0]  result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    overflow,
  output logic                    busy
);

  localparam int PC_WIDTH = $clog2(NUM_CHECKERS + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    IDLE  = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [1:0]               drain_cnt;
  logic [1:0]               drain_cnt_next;
  logic                     load_result;
  logic                     handshake;

  logic [NUM_CHECKERS-1:0]  jv;
  logic [PC_WIDTH-1:0]      pc;
  logic [PC_WIDTH-1:0]      pc_next;
  logic [COUNT_WIDTH-1:0]   total;
  logic [COUNT_WIDTH:0]     sum_full;
  logic [COUNT_WIDTH-1:0]   total_sum;
  logic                     carry;

  always_comb begin
    pc_next = '0;
    for (int i = 0; i < NUM_CHECKERS; i++) begin
      pc_next = pc_next + PC_WIDTH'(jv[i]);
    end
  end

  // Saturating add: carry-out pins the total at all-ones.
  always_comb begin
    sum_full  = {1'b0, total} + (COUNT_WIDTH + 1)'(pc);
    carry     = sum_full[COUNT_WIDTH];
    total_sum = carry ? '1 : sum_full[COUNT_WIDTH-1:0];
  end

  assign handshake = result_valid && result_ready;
  assign busy      = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    load_result    = 1'b0;
    if (clear) begin
      state_next     = RUN;
      drain_cnt_next = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (&done) begin
            state_next     = DRAIN;
            drain_cnt_next = 2'd2;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd1) begin
            state_next  = HOLD;
            load_result = 1'b1;
          end else begin
            drain_cnt_next = drain_cnt - 2'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state_next = IDLE;
          end
        end
        IDLE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // The result captures the sum being written on the DRAIN->HOLD edge, so the
  // last hits sampled alongside &done are included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jv           <= '0;
      pc           <= '0;
      total        <= '0;
      overflow     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (clear) begin
      jv           <= '0;
      pc           <= '0;
      total        <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      jv <= ((state == HOLD) || (state == IDLE)) ? '0 : jump;
      pc <= pc_next;
      if (state != IDLE) begin
        total <= total_sum;
        if (carry) begin
          overflow <= 1'b1;
        end
      end
      if (load_result) begin
        result       <= total_sum;
        result_valid <= 1'b1;
      end else if ((state == HOLD) && handshake) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jump_count_aggregator.sv
// +----------------------------------------------------------------------------+
// | tb_jump_count_aggregator: self-checking bench, wide and 4-bit counters.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_jump_count_aggregator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  jump = '0;
  logic [3:0]  done = '0;
  logic        result_ready = 1'b0;

  logic [31:0] result;
  logic        result_valid;
  logic        overflow;
  logic        busy;
  logic [3:0]  result_n;
  logic        result_valid_n;
  logic        overflow_n;
  logic        busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  jump_count_aggregator #(.NUM_CHECKERS(4), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .jump(jump), .done(done),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .overflow(overflow), .busy(busy)
  );

  jump_count_aggregator #(.NUM_CHECKERS(4), .COUNT_WIDTH(4)) dut_n (
    .clk(clk), .reset_n(reset_n), .clear(clear), .jump(jump), .done(done),
    .result(result_n), .result_valid(result_valid_n), .result_ready(result_ready),
    .overflow(overflow_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    int          cycles;
    logic [31:0] exp32;
    logic [3:0]  exp4;
    bit          ovf4;
    int          stall;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] j, input logic [3:0] d);
    jump = j;
    done = d;
    tick();
  endtask

  // Restart both counters; the jump bits driven during clear must be dropped.
  task automatic start_clear();
    clear = 1'b1;
    jump  = 4'($urandom);
    done  = 4'hF;
    tick();
    clear = 1'b0;
    jump  = '0;
    done  = '0;
    check("clear_valid", result_valid, 0);
    check("clear_busy", busy, 1);
    check("clear_ovf_n", overflow_n, 0);
  endtask

  // Called right after the cycle in which &done was driven.
  task automatic finish_txn(input string name, input logic [31:0] exp32,
                            input logic [3:0] exp4, input bit ovf4, input int stall);
    int lat;
    lat  = 1;
    jump = '0;
    done = '0;
    while (!result_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_result"}, result, exp32);
    check({name, "_result_n"}, result_n, exp4);
    check({name, "_valid_n"}, result_valid_n, 1);
    check({name, "_ovf_n"}, overflow_n, ovf4);
    check({name, "_ovf"}, overflow, 0);
    check({name, "_busy_hold"}, busy, 0);
    for (int i = 0; i < stall; i++) begin
      jump = 4'($urandom);
      tick();
      check({name, "_stall_valid"}, result_valid, 1);
      check({name, "_stall_result"}, result, exp32);
    end
    jump = '0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({name, "_valid_after_hs"}, result_valid, 0);
    check({name, "_busy_idle"}, busy, 0);
    tick();
    check({name, "_idle_valid"}, result_valid, 0);
    check({name, "_idle_result"}, result, exp32);
  endtask

  initial begin
    int unsigned sum;
    int          ncyc;
    logic [3:0]  j;

    tbl[0] = '{4'b0101, 1,  32'd2,  4'd2,  1'b0, 0};
    tbl[1] = '{4'hF,    10, 32'd40, 4'd15, 1'b1, 20};
    tbl[2] = '{4'hF,    5,  32'd20, 4'd15, 1'b1, 2};
    tbl[3] = '{4'b1000, 3,  32'd3,  4'd3,  1'b0, 1};
    tbl[4] = '{4'h7,    5,  32'd15, 4'd15, 1'b0, 0};
    tbl[5] = '{4'hF,    4,  32'd16, 4'd15, 1'b1, 3};
    tbl[6] = '{4'h0,    1,  32'd0,  4'd0,  1'b0, 0};

    #3 reset_n = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 1);
    #28 reset_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      start_clear();
      for (int c = 0; c < tbl[k].cycles; c++) begin
        send(tbl[k].pat, (c == tbl[k].cycles - 1) ? 4'hF : 4'h0);
      end
      finish_txn($sformatf("tbl%0d", k), tbl[k].exp32, tbl[k].exp4, tbl[k].ovf4, tbl[k].stall);
    end

    // Clear while draining throws away the 7 earlier hits.
    start_clear();
    send(4'hF, 4'h0);
    send(4'b0111, 4'hF);
    clear = 1'b1;
    jump  = 4'hF;
    tick();
    clear = 1'b0;
    jump  = '0;
    check("drain_clear_busy", busy, 1);
    check("drain_clear_valid", result_valid, 0);
    send(4'b0001, 4'h0);
    send(4'b0001, 4'h0);
    send(4'b0001, 4'hF);
    finish_txn("drain_clear", 32'd3, 4'd3, 1'b0, 0);

    // Clear and handshake in the same cycle: clear wins.
    start_clear();
    send(4'b0011, 4'hF);
    jump = '0;
    done = '0;
    for (int i = 0; i < 20 && !result_valid; i++) tick();
    check("clr_hs_valid_before", result_valid, 1);
    clear = 1'b1;
    result_ready = 1'b1;
    tick();
    clear = 1'b0;
    result_ready = 1'b0;
    check("clr_hs_valid", result_valid, 0);
    check("clr_hs_busy", busy, 1);
    send(4'b0001, 4'hF);
    finish_txn("clr_hs", 32'd1, 4'd1, 1'b0, 0);

    // Asynchronous reset mid-RUN with 9 hits accumulated.
    start_clear();
    send(4'hF, 4'h0);
    send(4'hF, 4'h0);
    send(4'b0100, 4'h0);
    send(4'h0, 4'h0);
    send(4'h0, 4'h0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_result", result, 0);
    check("async_rst_valid", result_valid, 0);
    check("async_rst_busy", busy, 1);
    done = 4'hF;
    @(posedge clk);
    #1;
    check("async_rst_valid_held", result_valid, 0);
    done = '0;
    #2 reset_n = 1'b1;
    tick();
    send(4'b0010, 4'hF);
    finish_txn("after_rst", 32'd1, 4'd1, 1'b0, 0);

    // Randomized transactions against a popcount-sum model.
    for (int k = 0; k < 25; k++) begin
      start_clear();
      sum  = 0;
      ncyc = $urandom_range(1, 12);
      for (int c = 0; c < ncyc; c++) begin
        j = 4'($urandom);
        sum += $countones(j);
        send(j, (c == ncyc - 1) ? 4'hF : 4'($urandom_range(0, 14)));
      end
      finish_txn($sformatf("rand%0d", k), sum, (sum > 15) ? 4'd15 : 4'(sum),
                 sum > 15, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
